// File: rtl/clock_phase_sequencer_pkg.sv
// Shared encodings for the clock phase sequencer: FSM states, phase indices and strobe decode.
package clock_phase_sequencer_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] PH_IMEM    = 2'd0;
    localparam logic [1:0] PH_REGFILE = 2'd1;
    localparam logic [1:0] PH_PROC    = 2'd2;
    localparam logic [1:0] PH_DMEM    = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD = ST_HOLD,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT
    } state_t;

    // Bit order of the result is {dmem, proc, regfile, imem}.
    function automatic logic [3:0] phase_strobe(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/clock_phase_sequencer_reset_sync.sv
// Reset synchronizer: asserts immediately with reset_in, releases two clock edges after reset_in falls.
module reset_sync (
    input  logic clock,
    input  logic reset_in,
    output logic reset_out
);

    logic [1:0] sync;

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], 1'b0};
        end
    end

    assign reset_out = sync[1];

endmodule

// File: rtl/clock_phase_sequencer.sv
// Four-phase strobe sequencer (imem, regfile, proc, dmem) with post-reset hold, halt/resume and a
// saturating frame counter; all outputs are registered so strobes are always whole clock cycles.
module clock_phase_sequencer
    import clock_phase_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic             resume,
    output logic             core_reset,
    output logic             imem_en,
    output logic             regfile_en,
    output logic             proc_en,
    output logic             dmem_en,
    output logic             running,
    output logic [CNT_W-1:0] frame_count
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic              sync_reset;
    state_t            state;
    logic [1:0]        phase;
    logic [HOLD_W-1:0] hold_cnt;
    logic              halt_latched;
    logic [3:0]        strobes;
    logic              hold_done;
    logic [CNT_W-1:0]  frame_next;

    reset_sync u_reset_sync (
        .clock     (clock),
        .reset_in  (reset),
        .reset_out (sync_reset)
    );

    // HOLD_CYCLES of 0 or 1 both still cost exactly one HOLD cycle.
    assign hold_done  = (HOLD_CYCLES <= 1) || (int'(hold_cnt) == HOLD_CYCLES - 1);
    assign frame_next = (&frame_count) ? frame_count : frame_count + CNT_W'(1);

    always_ff @(posedge clock or posedge sync_reset) begin
        if (sync_reset) begin
            state        <= S_HOLD;
            core_reset   <= 1'b1;
            strobes      <= 4'b0000;
            running      <= 1'b0;
            phase        <= PH_IMEM;
            hold_cnt     <= '0;
            frame_count  <= '0;
            halt_latched <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_done) begin
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                        phase      <= PH_IMEM;
                        strobes    <= phase_strobe(PH_IMEM);
                    end
                end
                S_RUN: begin
                    if (phase == PH_DMEM) begin
                        frame_count <= frame_next;
                        // A halt seen anywhere in the frame, including this last cycle, stops here.
                        if (halt_latched || halt) begin
                            state        <= S_HALT;
                            running      <= 1'b0;
                            phase        <= PH_IMEM;
                            strobes      <= 4'b0000;
                            halt_latched <= 1'b0;
                        end else begin
                            phase   <= PH_IMEM;
                            strobes <= phase_strobe(PH_IMEM);
                        end
                    end else begin
                        halt_latched <= halt_latched | halt;
                        phase        <= phase + 2'd1;
                        strobes      <= phase_strobe(phase + 2'd1);
                    end
                end
                S_HALT: begin
                    halt_latched <= 1'b0;
                    phase        <= PH_IMEM;
                    strobes      <= 4'b0000;
                    if (resume) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        strobes <= phase_strobe(PH_IMEM);
                    end
                end
                default: begin
                    state      <= S_HOLD;
                    core_reset <= 1'b1;
                    running    <= 1'b0;
                    strobes    <= 4'b0000;
                    phase      <= PH_IMEM;
                    hold_cnt   <= '0;
                end
            endcase
        end
    end

    assign imem_en    = strobes[0];
    assign regfile_en = strobes[1];
    assign proc_en    = strobes[2];
    assign dmem_en    = strobes[3];

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Bench for clock_phase_sequencer: default instance against a frame-level model, plus a
// HOLD_CYCLES=0 / CNT_W=4 instance for minimum hold and counter saturation.
module tb_clock_phase_sequencer;

    logic clock = 1'b0;
    logic reset, halt, resume;
    logic halt4 = 1'b0, resume4 = 1'b0;

    logic        core_reset, imem_en, regfile_en, proc_en, dmem_en, running;
    logic [31:0] frame_count;
    logic        core_reset4, imem_en4, regfile_en4, proc_en4, dmem_en4, running4;
    logic [3:0]  frame_count4;
    logic [3:0]  strobes;

    assign strobes = {dmem_en, proc_en, regfile_en, imem_en};

    clock_phase_sequencer #(.HOLD_CYCLES(16), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .halt(halt), .resume(resume),
        .core_reset(core_reset), .imem_en(imem_en), .regfile_en(regfile_en),
        .proc_en(proc_en), .dmem_en(dmem_en), .running(running), .frame_count(frame_count)
    );

    clock_phase_sequencer #(.HOLD_CYCLES(0), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .halt(halt4), .resume(resume4),
        .core_reset(core_reset4), .imem_en(imem_en4), .regfile_en(regfile_en4),
        .proc_en(proc_en4), .dmem_en(dmem_en4), .running(running4), .frame_count(frame_count4)
    );

    always #10 clock = ~clock;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int s4 = 0;

    // Frame-level model: cycles since entering RUN decide the strobe; a halt request made
    // while running stops the machine at the end of the current 4-cycle frame.
    bit m_started = 0, m_running = 0, m_req = 0;
    int m_runcyc = 0, m_frames = 0;

    function automatic logic [3:0] exp_strobes();
        return m_running ? (4'b0001 << (m_runcyc % 4)) : 4'b0000;
    endfunction

    task automatic step();
        if (m_running) begin
            if (halt) m_req = 1;
            if (m_runcyc % 4 == 3) begin
                m_frames++;
                if (m_req) begin
                    m_running = 0;
                    m_req = 0;
                end
            end
            m_runcyc++;
        end else if (m_started && resume) begin
            m_running = 1;
            m_runcyc = 0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int fall, fall4;
        fall = 0;
        fall4 = 0;
        reset = 1'b0; halt = 1'b0; resume = 1'b0;
        #2 reset = 1'b1;
        #3;
        total++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset); else passed++;
        total++; if (strobes !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", strobes); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else passed++;
        total++; if (frame_count !== 32'd0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else passed++;
        total++; if (core_reset4 !== 1'b1) $display("FAIL reset_core_reset4: got %b want 1", core_reset4); else passed++;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 100 && (fall == 0 || fall4 == 0); i++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (fall4 == 0 && core_reset4 == 1'b0) begin
                fall4 = cyc;
                s4 = cyc;
            end
            if (fall == 0 && core_reset == 1'b0) fall = cyc;
        end
        total++; if (fall !== 18) $display("FAIL hold_length: core_reset fell after %0d edges, want 18", fall); else passed++;
        total++; if (fall4 !== 3) $display("FAIL hold_zero_length: core_reset fell after %0d edges, want 3", fall4); else passed++;
        total++; if (imem_en !== 1'b1) $display("FAIL first_imem: got %b want 1", imem_en); else passed++;
        total++; if (running !== 1'b1) $display("FAIL first_running: got %b want 1", running); else passed++;
        m_started = 1;
        m_running = 1;
        m_runcyc = 0;
        m_frames = 0;
    endtask

    task automatic test_frames();
        for (int i = 0; i < 40; i++) begin
            step();
            total++; if (strobes !== exp_strobes()) $display("FAIL frame_strobes[%0d]: got %b want %b", i, strobes, exp_strobes()); else passed++;
            total++; if ($countones(strobes) != 1) $display("FAIL frame_onehot[%0d]: got %0d strobes high want 1", i, $countones(strobes)); else passed++;
            total++; if (frame_count !== 32'(m_frames)) $display("FAIL frame_count[%0d]: got %0d want %0d", i, frame_count, m_frames); else passed++;
        end
        total++; if (frame_count !== 32'd10) $display("FAIL ten_frames: got %0d want 10", frame_count); else passed++;
    endtask

    task automatic test_saturation();
        int exp4;
        for (int i = 0; i < 40; i++) begin
            step();
            exp4 = (cyc - s4) / 4;
            if (exp4 > 15) exp4 = 15;
            total++; if (frame_count4 !== 4'(exp4)) $display("FAIL sat_count[%0d]: got %0d want %0d", i, frame_count4, exp4); else passed++;
            total++; if (frame_count !== 32'(m_frames)) $display("FAIL sat_main_count[%0d]: got %0d want %0d", i, frame_count, m_frames); else passed++;
        end
        total++; if (frame_count4 !== 4'd15) $display("FAIL saturated: got %0d want 15", frame_count4); else passed++;
    endtask

    task automatic test_halt();
        logic [31:0] fc;
        for (int i = 0; i < 8 && (m_runcyc % 4) != 1; i++) step();
        total++; if (regfile_en !== 1'b1) $display("FAIL halt_at_regfile: got %b want 1", regfile_en); else passed++;
        halt = 1'b1;
        step();
        halt = 1'b0;
        total++; if (proc_en !== 1'b1) $display("FAIL halt_proc: got %b want 1", proc_en); else passed++;
        step();
        total++; if (dmem_en !== 1'b1) $display("FAIL halt_dmem: got %b want 1", dmem_en); else passed++;
        fc = frame_count;
        step();
        total++; if (running !== 1'b0) $display("FAIL halt_running: got %b want 0", running); else passed++;
        total++; if (frame_count !== fc + 32'd1) $display("FAIL halt_frame_done: got %0d want %0d", frame_count, fc + 32'd1); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (strobes !== 4'b0000) $display("FAIL halted_strobes[%0d]: got %b want 0000", i, strobes); else passed++;
            total++; if (frame_count !== fc + 32'd1) $display("FAIL halted_count[%0d]: got %0d want %0d", i, frame_count, fc + 32'd1); else passed++;
        end
    endtask

    task automatic test_resume_wins();
        halt = 1'b1;
        resume = 1'b1;
        step();
        halt = 1'b0;
        resume = 1'b0;
        total++; if (running !== 1'b1) $display("FAIL resume_wins_running: got %b want 1", running); else passed++;
        total++; if (imem_en !== 1'b1) $display("FAIL resume_wins_imem: got %b want 1", imem_en); else passed++;
        step();
        total++; if (regfile_en !== 1'b1) $display("FAIL resume_wins_regfile: got %b want 1", regfile_en); else passed++;
    endtask

    task automatic test_halt_on_entry();
        halt = 1'b1;
        step();
        halt = 1'b0;
        for (int i = 0; i < 8 && m_running; i++) step();
        total++; if (running !== 1'b0) $display("FAIL entry_pre_halt: got %b want 0", running); else passed++;
        resume = 1'b1;
        step();
        resume = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        step();
        total++; if (dmem_en !== 1'b1) $display("FAIL entry_dmem: got %b want 1", dmem_en); else passed++;
        step();
        total++; if (running !== 1'b0) $display("FAIL entry_halted: got %b want 0", running); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            halt = ($urandom_range(0, 9) == 0);
            resume = ($urandom_range(0, 3) == 0);
            step();
            total++; if (running !== m_running) $display("FAIL rand_running[%0d]: got %b want %b", i, running, m_running); else passed++;
            total++; if (strobes !== exp_strobes()) $display("FAIL rand_strobes[%0d]: got %b want %b", i, strobes, exp_strobes()); else passed++;
            total++; if (frame_count !== 32'(m_frames)) $display("FAIL rand_count[%0d]: got %0d want %0d", i, frame_count, m_frames); else passed++;
            total++; if (core_reset !== 1'b0) $display("FAIL rand_core_reset[%0d]: got %b want 0", i, core_reset); else passed++;
        end
        halt = 1'b0;
        resume = 1'b0;
    endtask

    task automatic test_async_reset();
        halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (m_running && (m_runcyc % 4) == 2) break;
            resume = !m_running;
            step();
        end
        resume = 1'b0;
        total++; if (proc_en !== 1'b1) $display("FAIL pre_reset_proc: got %b want 1", proc_en); else passed++;
        #5 reset = 1'b1;
        #1;
        total++; if (proc_en !== 1'b0) $display("FAIL async_proc: got %b want 0", proc_en); else passed++;
        total++; if (running !== 1'b0) $display("FAIL async_running: got %b want 0", running); else passed++;
        total++; if (core_reset !== 1'b1) $display("FAIL async_core_reset: got %b want 1", core_reset); else passed++;
        total++; if (frame_count !== 32'd0) $display("FAIL async_count: got %0d want 0", frame_count); else passed++;
        total++; if (frame_count4 !== 4'd0) $display("FAIL async_count4: got %0d want 0", frame_count4); else passed++;
        #40 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_saturation();
        test_halt();
        test_resume_wins();
        test_halt_on_entry();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
